// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter for the single register-file write port.
// Each cycle it picks an ALU result (absolute priority) or the head of a
// small FIFO of long-latency (mul/div) results, drives the register-file
// write port from flops, and keeps a per-register pending scoreboard.
// Optional build macro: WB_ZERO_DROP_EN -- when defined, results and issues
// targeting r0 are discarded at the inputs (LU r0 transfers still handshake).
module wb_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_dst,
  input  logic [31:0]              alu_data,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [4:0]               lu_dst,
  input  logic [31:0]              lu_data,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_dst,
  output logic [31:0]              pending,
  output logic                     reg_write,
  output logic [4:0]               num_write,
  output logic [31:0]              data_write,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

  // FIFO storage and bookkeeping
  logic [4:0]    dst_mem_q  [DEPTH];
  logic [4:0]    dst_mem_d  [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   data_mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          lu_ready_q, lu_ready_d;

  // Scoreboard and register-file write port
  logic [31:0]   pending_q, pending_d;
  logic          reg_write_q, reg_write_d;
  logic [4:0]    num_write_q, num_write_d;
  logic [31:0]   data_write_q, data_write_d;

  // Per-cycle decisions
  logic          alu_take_s;
  logic          lu_enq_s;
  logic          issue_set_s;
  logic          fifo_deq_s;
  logic [4:0]    head_dst_s;
  logic [31:0]   head_data_s;
  logic [31:0]   clr_mask_s;
  logic [31:0]   set_mask_s;

  assign head_dst_s  = dst_mem_q[rd_ptr_q];
  assign head_data_s = data_mem_q[rd_ptr_q];

  // Qualify the incoming requests; r0 traffic is filtered when dropping is enabled.
  always_comb begin
`ifdef WB_ZERO_DROP_EN
    alu_take_s  = alu_valid & (alu_dst != 5'd0);
    lu_enq_s    = lu_valid & lu_ready_q & (lu_dst != 5'd0);
    issue_set_s = issue_valid & (issue_dst != 5'd0);
`else
    alu_take_s  = alu_valid;
    lu_enq_s    = lu_valid & lu_ready_q;
    issue_set_s = issue_valid;
`endif
    // The FIFO only drains when the ALU does not claim the port; never bypassed.
    fifo_deq_s = ~alu_take_s & (count_q != ZERO_CNT);
  end

  // FIFO next state: storage write, pointer advance, occupancy and ready flag.
  always_comb begin
    dst_mem_d  = dst_mem_q;
    data_mem_d = data_mem_q;
    if (lu_enq_s) begin
      dst_mem_d[wr_ptr_q]  = lu_dst;
      data_mem_d[wr_ptr_q] = lu_data;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (fifo_deq_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({lu_enq_s, fifo_deq_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Ready is a flop so it only moves on clock edges and never sees lu_valid.
    lu_ready_d = (count_d != FULL_CNT);
  end

  // Write-port select: ALU first, then FIFO head, else hold address/data.
  always_comb begin
    if (alu_take_s) begin
      reg_write_d  = 1'b1;
      num_write_d  = alu_dst;
      data_write_d = alu_data;
    end else if (fifo_deq_s) begin
      reg_write_d  = 1'b1;
      num_write_d  = head_dst_s;
      data_write_d = head_data_s;
    end else begin
      reg_write_d  = 1'b0;
      num_write_d  = num_write_q;
      data_write_d = data_write_q;
    end
  end

  // Scoreboard: FIFO writes clear, issues set (set wins), r0 never pending.
  always_comb begin
    clr_mask_s = fifo_deq_s  ? (32'd1 << head_dst_s) : 32'd0;
    set_mask_s = issue_set_s ? (32'd1 << issue_dst)  : 32'd0;
    pending_d  = ((pending_q & ~clr_mask_s) | set_mask_s) & ~32'd1;
  end

  // State registers; asynchronous reset flushes FIFO, scoreboard and write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dst_mem_q[i]  <= 5'd0;
        data_mem_q[i] <= 32'd0;
      end
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= ZERO_CNT;
      lu_ready_q   <= 1'b1;
      pending_q    <= 32'd0;
      reg_write_q  <= 1'b0;
      num_write_q  <= 5'd0;
      data_write_q <= 32'd0;
    end else begin
      dst_mem_q    <= dst_mem_d;
      data_mem_q   <= data_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      lu_ready_q   <= lu_ready_d;
      pending_q    <= pending_d;
      reg_write_q  <= reg_write_d;
      num_write_q  <= num_write_d;
      data_write_q <= data_write_d;
    end
  end

  assign lu_ready   = lu_ready_q;
  assign fifo_count = count_q;
  assign pending    = pending_q;
  assign reg_write  = reg_write_q;
  assign num_write  = num_write_q;
  assign data_write = data_write_q;

endmodule
